cv32e40p_tmr_fault_ctrl: RTL
============================

Name: cv32e40p_tmr_fault_ctrl

Overview:
- Supervises a triple-modular-redundant datapath using the per-replica error flags of its majority voter.
- Sorts transient from permanent faults with leaky per-replica error counters.
- Requests resynchronisation of a faulty replica, and drops to duplex operation once a replica is declared permanently bad.
- Raises a sticky fatal flag when the voter can no longer guarantee a correct result.

Parameters:
ERR_THRESHOLD, 4, error count at which a replica is declared permanently faulty (1..2^CNT_W-1)
CNT_W, 4, width of each per-replica error counter
RESYNC_CYCLES, 8, maximum cycles to wait for resync_ack_i before declaring the replica permanent
LEAK_WINDOW, 64, number of error-free valid votes after which every nonzero counter decrements by 1

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, reset asynchronous active-low
vote_valid_i  in  1  voter outputs meaningful this cycle
err_i  in  3  voter per-replica error flags, bit k = replica k+1 disagrees
clear_i  in  1  synchronous recovery: return to TMR, clear counters
resync_ack_i  in  1  resync of replica resync_id_o completed
replica_en_o  out  3  active-replica mask
resync_req_o  out  1  request state copy into replica resync_id_o
resync_id_o  out  2  replica index 0..2 being resynced
fatal_o  out  1  sticky uncorrectable-fault flag
state_o  out  2  0=TMR 1=RESYNC 2=DMR 3=FATAL
err_cnt_o  out  3*CNT_W  counters {c2,c1,c0}

Behaviour:
- Reset values: state TMR, replica_en_o=3'b111, resync_req_o=0, resync_id_o=0, fatal_o=0, all counters 0, leak counter 0, timeout counter 0.
- All outputs are registered. The response to an err_i sample appears on the next cycle.
- err_i is ignored when vote_valid_i=0.
- Priority: rst_n > clear_i > error events > leak.
- clear_i from any state: next state TMR, mask 111, counters 0, fatal_o=0, resync_req_o=0.

TMR state:
- err_i=000: leak counter increments. On reaching LEAK_WINDOW it wraps to 0 and every nonzero counter decrements by 1.
- Exactly one bit k set:
  - c_k increments, saturating at ERR_THRESHOLD; the leak counter resets to 0.
  - If the new c_k equals ERR_THRESHOLD: go to DMR and clear bit k of the mask.
  - Otherwise: go to RESYNC with resync_id_o=k and resync_req_o=1.
- err_i=111 or any two bits set: go to FATAL.

RESYNC state:
- resync_req_o is held at 1 until resync_ack_i is sampled high.
- On ack: go to TMR, resync_req_o=0, timeout counter cleared.
- No ack within RESYNC_CYCLES cycles of entry: go to DMR with bit resync_id_o of the mask cleared, resync_req_o=0.
- An error on the replica being resynced is ignored. An error on any other replica goes to FATAL.
- When ack and the timeout coincide, ack wins.
- Leak is frozen in this state.

DMR state:
- Errors on the masked replica are ignored.
- An error bit on either active replica goes to FATAL, because a single disagreement between two replicas cannot be resolved.
- Counters and leak are frozen.
- resync_req_o=0.

FATAL state:
- fatal_o=1; the mask is unchanged from the state it was entered from.
- Only rst_n or clear_i exits this state.

Other rules:
- Counter saturation: never exceeds ERR_THRESHOLD; a decrement at 0 keeps it at 0.
- resync_id_o holds its last value outside RESYNC.
- Reset asserted mid-resync: the request drops asynchronously to 0.

Test Plan:
- Reset, then 100 valid votes with err_i=000 -> state_o=0, replica_en_o=111, fatal_o=0, counters 0.
- One valid vote with err_i=010, then resync_ack_i=1 three cycles later:
  - Next cycle: state_o=1, resync_id_o=1, resync_req_o=1, c1=1.
  - Cycle after the ack: state_o=0, resync_req_o=0.
- Four err_i=001 events, each acked, with fewer than 64 clean votes between them -> after the fourth: state_o=2, replica_en_o=110, c0=4; a later err_i=001 gives no change.
- err_i=100 with no ack for 8 cycles -> state_o=2, replica_en_o=011; then err_i=001 -> state_o=3, fatal_o=1.
- Single err_i=001 acked, then 64 clean valid votes -> c0 returns to 0. In RESYNC for id 0, err_i=010 -> FATAL.
- Two cycles after entering FATAL via err_i=111, pulse clear_i -> state_o=0, mask 111, fatal_o=0, counters 0. clear_i together with err_i=111 in the same cycle -> TMR.

Source files
------------

// File: rtl/cv32e40p_tmr_fault_ctrl.sv
// rtl/cv32e40p_tmr_fault_ctrl.sv - TMR fault supervisor: leaky error counters, resync, duplex fallback
module cv32e40p_tmr_fault_ctrl #(
  parameter int ERR_THRESHOLD = 4,
  parameter int CNT_W         = 4,
  parameter int RESYNC_CYCLES = 8,
  parameter int LEAK_WINDOW   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vote_valid_i,
  input  logic [2:0]         err_i,
  input  logic               clear_i,
  input  logic               resync_ack_i,
  output logic [2:0]         replica_en_o,
  output logic               resync_req_o,
  output logic [1:0]         resync_id_o,
  output logic               fatal_o,
  output logic [1:0]         state_o,
  output logic [3*CNT_W-1:0] err_cnt_o
);

  localparam int LEAK_W = $clog2(LEAK_WINDOW + 1);
  localparam int TMO_W  = $clog2(RESYNC_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(ERR_THRESHOLD);
  localparam logic [LEAK_W-1:0] LEAK_END = LEAK_W'(LEAK_WINDOW - 1);
  localparam logic [TMO_W-1:0]  TMO_END  = TMO_W'(RESYNC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_TMR    = 2'd0,
    S_RESYNC = 2'd1,
    S_DMR    = 2'd2,
    S_FATAL  = 2'd3
  } state_e;

  state_e             state_q, state_n;
  logic [2:0]         mask_q, mask_n;
  logic               req_q, req_n;
  logic [1:0]         id_q, id_n;
  logic               fatal_q, fatal_n;
  logic [CNT_W-1:0]   cnt_q [3];
  logic [CNT_W-1:0]   cnt_n [3];
  logic [LEAK_W-1:0]  leak_q, leak_n;
  logic [TMO_W-1:0]   tmo_q, tmo_n;
  logic [1:0]         err_idx;
  logic [CNT_W-1:0]   cnt_inc;
  logic [2:0]         err_other;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_TMR;
      mask_q  <= 3'b111;
      req_q   <= 1'b0;
      id_q    <= 2'd0;
      fatal_q <= 1'b0;
      leak_q  <= '0;
      tmo_q   <= '0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_n;
      mask_q  <= mask_n;
      req_q   <= req_n;
      id_q    <= id_n;
      fatal_q <= fatal_n;
      leak_q  <= leak_n;
      tmo_q   <= tmo_n;
      for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_n[k];
    end
  end

  always_comb begin
    state_n   = state_q;
    mask_n    = mask_q;
    req_n     = req_q;
    id_n      = id_q;
    fatal_n   = fatal_q;
    leak_n    = leak_q;
    tmo_n     = tmo_q;
    for (int k = 0; k < 3; k++) cnt_n[k] = cnt_q[k];
    err_idx   = err_i[1] ? 2'd1 : (err_i[2] ? 2'd2 : 2'd0);
    cnt_inc   = (cnt_q[err_idx] == CNT_MAX) ? cnt_q[err_idx] : cnt_q[err_idx] + 1'b1;
    err_other = err_i & ~(3'b001 << id_q);

    if (clear_i) begin
      state_n = S_TMR;
      mask_n  = 3'b111;
      req_n   = 1'b0;
      fatal_n = 1'b0;
      leak_n  = '0;
      tmo_n   = '0;
      for (int k = 0; k < 3; k++) cnt_n[k] = '0;
    end else begin
      case (state_q)
        S_TMR: begin
          if (vote_valid_i) begin
            if (err_i == 3'b000) begin
              if (leak_q == LEAK_END) begin
                leak_n = '0;
                for (int k = 0; k < 3; k++)
                  if (cnt_q[k] != '0) cnt_n[k] = cnt_q[k] - 1'b1;
              end else begin
                leak_n = leak_q + 1'b1;
              end
            end else if ($onehot(err_i)) begin
              leak_n          = '0;
              cnt_n[err_idx]  = cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state_n         = S_DMR;
                mask_n[err_idx] = 1'b0;
              end else begin
                state_n = S_RESYNC;
                id_n    = err_idx;
                req_n   = 1'b1;
                tmo_n   = '0;
              end
            end else begin
              state_n = S_FATAL;
              fatal_n = 1'b1;
            end
          end
        end
        S_RESYNC: begin
          // Errors from the replica under resync are expected and ignored.
          if (vote_valid_i && err_other != 3'b000) begin
            state_n = S_FATAL;
            fatal_n = 1'b1;
            req_n   = 1'b0;
            tmo_n   = '0;
          end else if (resync_ack_i) begin
            state_n = S_TMR;
            req_n   = 1'b0;
            tmo_n   = '0;
          end else if (tmo_q == TMO_END) begin
            state_n      = S_DMR;
            mask_n[id_q] = 1'b0;
            req_n        = 1'b0;
            tmo_n        = '0;
          end else begin
            tmo_n = tmo_q + 1'b1;
          end
        end
        S_DMR: begin
          if (vote_valid_i && (err_i & mask_q) != 3'b000) begin
            state_n = S_FATAL;
            fatal_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign replica_en_o = mask_q;
  assign resync_req_o = req_q;
  assign resync_id_o  = id_q;
  assign fatal_o      = fatal_q;
  assign state_o      = state_q;
  assign err_cnt_o    = {cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule
